// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Used by if_pc_gen and if_fetch_unit (optional trap mode: IF_FAULT_TRAP_EN).
package if_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    STEP_WAIT = 2'd1,
    FAULT     = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
  localparam int unsigned PC_STEP      = 4;

endpackage

// File: rtl/if_pc_gen.sv
// PC register with redirect/stall priority mux and combinational fault detect.
// IF_FAULT_TRAP_EN: a faulting PC is replaced by TRAP_VEC on the next edge.
module if_pc_gen
  import if_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     IMEM_AW  = 10,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0004)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_target,
  input  logic            i_stall,
  input  logic            i_advance,
  output logic [XLEN-1:0] o_pc,
  output logic            o_fault_det
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;

  // Misaligned, or beyond the last ROM word.
  assign o_fault_det = (r_pc[1:0] != 2'b00) || (r_pc[XLEN-1:IMEM_AW+2] != '0);

  always_comb begin
    w_pc_next = r_pc;
    if (i_redirect) begin
      w_pc_next = i_target;
    end
`ifdef IF_FAULT_TRAP_EN
    else if (o_fault_det) begin
      w_pc_next = TRAP_VEC;
    end
`endif
    else if (i_stall) begin
      w_pc_next = r_pc;
    end else if (i_advance) begin
      w_pc_next = r_pc + XLEN'(PC_STEP);
    end
  end

`ifndef IF_FAULT_TRAP_EN
  logic w_unused_trap;
  assign w_unused_trap = ^TRAP_VEC;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: fetch FSM (run / single-step / fault) and the IF/ID register.
// IF_FAULT_TRAP_EN: faults redirect to TRAP_VEC with a one-cycle fault pulse instead of a sticky FAULT state.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     IMEM_AW  = 10,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0004),
  parameter logic [XLEN-1:0] NOP_WORD = XLEN'(NOP_WORD_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               jump,
  input  logic               PCSrc,
  input  logic [XLEN-1:0]    pcchange,
  input  logic               one_step_en,
  input  logic               step,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    pc_o,
  output logic [XLEN-1:0]    pcplus_o,
  output logic [XLEN-1:0]    ir_o,
  output logic               valid_o,
  output logic               fault
);

  logic            w_redirect;
  logic            w_fault_det;
  logic            w_fetch;
  logic [XLEN-1:0] w_pc;
  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [XLEN-1:0] r_pc_o;
  logic [XLEN-1:0] r_pcplus_o;
  logic [XLEN-1:0] r_ir;
  logic            r_valid;

  assign w_redirect = jump | PCSrc;

  if_pc_gen #(
    .XLEN     (XLEN),
    .IMEM_AW  (IMEM_AW),
    .RESET_PC (RESET_PC),
    .TRAP_VEC (TRAP_VEC)
  ) u_pc_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_redirect  (w_redirect),
    .i_target    (pcchange),
    .i_stall     (stall),
    .i_advance   (w_fetch),
    .o_pc        (w_pc),
    .o_fault_det (w_fault_det)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_fetch      = 1'b0;
    case (r_state)
      RUN, STEP_WAIT: begin
        // In single-step mode a fetch is issued only on a step pulse.
        w_fetch      = !w_redirect && !stall && !w_fault_det && (!one_step_en || step);
        w_state_next = one_step_en ? STEP_WAIT : RUN;
      end
      default: begin
        w_state_next = r_state;
      end
    endcase
`ifndef IF_FAULT_TRAP_EN
    if (!w_redirect && w_fault_det) begin
      w_state_next = FAULT;
    end
`endif
    if (w_redirect) begin
      w_state_next = one_step_en ? STEP_WAIT : RUN;
    end
  end

`ifdef IF_FAULT_TRAP_EN
  logic r_fault;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
    end else begin
      r_fault <= !w_redirect && w_fault_det;
    end
  end
  assign fault = r_fault;
`else
  assign fault = (r_state == FAULT);
`endif

  // Redirect squashes the wrong-path word even while stalled; flush kills regardless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_o     <= '0;
      r_pcplus_o <= '0;
      r_ir       <= NOP_WORD;
      r_valid    <= 1'b0;
    end else if (flush || w_redirect) begin
      r_ir    <= NOP_WORD;
      r_valid <= 1'b0;
    end else if (!stall) begin
      if (w_fetch) begin
        r_ir       <= imem_rdata;
        r_pc_o     <= w_pc;
        r_pcplus_o <= w_pc + XLEN'(PC_STEP);
        r_valid    <= 1'b1;
      end else begin
        r_ir    <= NOP_WORD;
        r_valid <= 1'b0;
      end
    end
  end

  assign imem_addr = w_pc[IMEM_AW+1:2];
  assign pc        = w_pc;
  assign pc_o      = r_pc_o;
  assign pcplus_o  = r_pcplus_o;
  assign ir_o      = r_ir;
  assign valid_o   = r_valid;

endmodule
